// File: rtl/ascon_enc_sequencer.sv
// ascon_enc_sequencer: sits between a 32-bit host load port and the Ascon encryption core.
// It collects key/nonce/AD/PT bytes over N_WORDS lane-packed writes and then fires core_start.
// It waits for core_ready under a watchdog, captures CT and tag, and streams CT||tag out as bytes.
// Ports:
//   clk, rst                  clock, async active-low reset
//   in_valid/in_ready/in_data host load word handshake, lanes {pt, ad, nonce, key}
//   go                        start request (ARMED) / error clear (ERROR)
//   core_key/nonce/ad/pt      held operands to the core
//   core_start                one-cycle start pulse
//   core_ready/ct/tag         core completion and results
//   out_valid/ready/data/last byte stream of CT||tag
//   busy, error               status
module ascon_enc_sequencer #(
  parameter int unsigned KEY_LEN = 128,
  parameter int unsigned AD_LEN  = 40,
  parameter int unsigned PT_LEN  = 40,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               go,
  output logic [KEY_LEN-1:0] core_key,
  output logic [127:0]       core_nonce,
  output logic [AD_LEN-1:0]  core_ad,
  output logic [PT_LEN-1:0]  core_pt,
  output logic               core_start,
  input  logic               core_ready,
  input  logic [PT_LEN-1:0]  core_ct,
  input  logic [127:0]       core_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic               busy,
  output logic               error
);

  localparam int unsigned MAX_A   = (KEY_LEN > 128) ? KEY_LEN : 128;
  localparam int unsigned MAX_B   = (AD_LEN > MAX_A) ? AD_LEN : MAX_A;
  localparam int unsigned MAX_LEN = (PT_LEN > MAX_B) ? PT_LEN : MAX_B;
  localparam int unsigned N_WORDS = MAX_LEN / 8;
  localparam int unsigned N_OUT   = PT_LEN / 8 + 16;
  localparam int unsigned IDX_W   = $clog2(N_WORDS + 1);
  localparam int unsigned OUT_W   = $clog2(N_OUT + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned SH_W    = PT_LEN + 128;

  typedef enum logic [2:0] {LOAD, ARMED, START, RUN, DRAIN, ERROR} state_t;

  state_t            state, stateNext;
  logic [IDX_W-1:0]  idx;
  logic [WD_W-1:0]   wd;
  logic [OUT_W-1:0]  outCnt;
  logic [SH_W-1:0]   outShift;
  logic              loadFire, drainFire;

  assign loadFire  = (state == LOAD) && in_valid;
  assign drainFire = (state == DRAIN) && out_ready;
  // Current output byte is always the top of the shifter, so it holds while stalled.
  assign out_data  = outShift[SH_W-1 -: 8];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      LOAD:  if (loadFire && (idx == IDX_W'(N_WORDS - 1))) stateNext = ARMED;
      ARMED: if (go) stateNext = START;
      START: stateNext = RUN;
      // core_ready takes priority over a watchdog expiring on the same cycle.
      RUN: begin
        if (core_ready)                      stateNext = DRAIN;
        else if (wd == WD_W'(TIMEOUT - 1))   stateNext = ERROR;
      end
      DRAIN: if (drainFire && out_last) stateNext = LOAD;
      ERROR: if (go) stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
  end

  // Datapath and registered status outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      wd         <= '0;
      outCnt     <= '0;
      outShift   <= '0;
      core_key   <= '0;
      core_nonce <= '0;
      core_ad    <= '0;
      core_pt    <= '0;
      core_start <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready   <= (stateNext == LOAD);
      busy       <= (stateNext != LOAD);
      error      <= (stateNext == ERROR);
      core_start <= (stateNext == START);
      out_valid  <= (stateNext == DRAIN);

      // Each field only takes lanes while its width still covers byte idx; MSB-first fill.
      if (loadFire) begin
        idx <= (idx == IDX_W'(N_WORDS - 1)) ? '0 : idx + IDX_W'(1);
        if (32'(idx) < KEY_LEN / 8) core_key   <= KEY_LEN'({core_key, in_data[7:0]});
        if (32'(idx) < 32'd16)      core_nonce <= 128'({core_nonce, in_data[15:8]});
        if (32'(idx) < AD_LEN / 8)  core_ad    <= AD_LEN'({core_ad, in_data[23:16]});
        if (32'(idx) < PT_LEN / 8)  core_pt    <= PT_LEN'({core_pt, in_data[31:24]});
      end

      if (state == START)    wd <= '0;
      else if (state == RUN) wd <= wd + WD_W'(1);

      if (state == ERROR && go) begin
        idx <= '0;
        wd  <= '0;
      end

      if (state == RUN && core_ready) begin
        outShift <= {core_ct, core_tag};
        outCnt   <= '0;
        out_last <= 1'b0;
      end else if (drainFire) begin
        outShift <= {outShift[SH_W-9:0], 8'h00};
        if (out_last) begin
          outCnt   <= '0;
          out_last <= 1'b0;
        end else begin
          outCnt   <= outCnt + OUT_W'(1);
          out_last <= (outCnt == OUT_W'(N_OUT - 2));
        end
      end
    end
  end

endmodule
